// File: rtl/itrx_aib_aux_sigfilt_pkg.sv
// +-------------------------------------------------------------------------+
// | itrx_aib_aux_pkg : shared types and constants for the aux receive path  |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

package itrx_aib_aux_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    QUAL_HI   = 2'd1,
    STABLE_HI = 2'd2,
    QUAL_LO   = 2'd3
  } aux_filt_state_t;

  localparam int                GLITCH_W   = 8;
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = 8'hFF;

  // Saturating increment for the rejected-transition counter.
  function automatic logic [GLITCH_W-1:0] glitch_inc(input logic [GLITCH_W-1:0] cnt);
    return (cnt == GLITCH_MAX) ? cnt : cnt + GLITCH_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/itrx_aib_aux_sigfilt_if.sv
// +-------------------------------------------------------------------------+
// | itrx_aib_aux_sigfilt_if : control/status bundle of the aux signal filter|
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

interface itrx_aib_aux_sigfilt_if;
  import itrx_aib_aux_pkg::*;

  logic                en;
  logic                lvs_out;
  logic                filt_out;
  logic                rise_pls;
  logic                fall_pls;
  logic                busy;
  logic [GLITCH_W-1:0] glitch_cnt;

  modport master (
    output en, lvs_out,
    input  filt_out, rise_pls, fall_pls, busy, glitch_cnt
  );

  modport slave (
    input  en, lvs_out,
    output filt_out, rise_pls, fall_pls, busy, glitch_cnt
  );

endinterface

`default_nettype wire

// File: rtl/itrx_aib_aux_sync.sv
// +-------------------------------------------------------------------------+
// | itrx_aib_aux_sync : N-stage flop synchronizer with selectable reset value|
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

module itrx_aib_aux_sync #(
  parameter int STAGES  = 2,
  parameter bit RST_VAL = 1'b0
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic d_i,
  output logic      q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/itrx_aib_aux_sigfilt.sv
// +-------------------------------------------------------------------------+
// | itrx_aib_aux_sigfilt : synchronize and debounce the level-shifted aux   |
// | signal; emits filtered level, edge pulses and a saturating glitch count |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

module itrx_aib_aux_sigfilt
  import itrx_aib_aux_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 16,
  parameter bit RST_LVL     = 1'b0
) (
  input  wire logic              clk,
  input  wire logic              rst,
  itrx_aib_aux_sigfilt_if.slave  aux_if
);

  localparam int              CNT_W       = $clog2(DEB_CYCLES) + 1;
  localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'(DEB_CYCLES - 1);
  localparam aux_filt_state_t c_rst_state = RST_LVL ? STABLE_HI : STABLE_LO;

  logic                s_sync;
  aux_filt_state_t     state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic                filt_q, filt_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
  logic                busy_q, busy_d;

  itrx_aib_aux_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (RST_LVL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (aux_if.lvs_out),
    .q_o (s_sync)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    glitch_d = glitch_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (!aux_if.en) begin
      // Disable snaps silently to the reset level: no pulses, no glitch count.
      state_d = c_rst_state;
      cnt_d   = '0;
    end else begin
      case (state_q)
        STABLE_LO: begin
          if (s_sync) begin
            state_d = QUAL_HI;
            cnt_d   = CNT_W'(1);
          end
        end
        QUAL_HI: begin
          if (!s_sync) begin
            state_d  = STABLE_LO;
            cnt_d    = '0;
            glitch_d = glitch_inc(glitch_q);
          end else if (cnt_q == c_cnt_last) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        STABLE_HI: begin
          if (!s_sync) begin
            state_d = QUAL_LO;
            cnt_d   = CNT_W'(1);
          end
        end
        QUAL_LO: begin
          if (s_sync) begin
            state_d  = STABLE_HI;
            cnt_d    = '0;
            glitch_d = glitch_inc(glitch_q);
          end else if (cnt_q == c_cnt_last) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = c_rst_state;
          cnt_d   = '0;
        end
      endcase
    end
    // Filtered level and busy follow the next state so they stay in step with it.
    filt_d = (state_d == STABLE_HI) || (state_d == QUAL_LO);
    busy_d = (state_d == QUAL_HI) || (state_d == QUAL_LO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= c_rst_state;
      cnt_q    <= '0;
      glitch_q <= '0;
      filt_q   <= RST_LVL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      glitch_q <= glitch_d;
      filt_q   <= filt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      busy_q   <= busy_d;
    end
  end

  assign aux_if.filt_out   = filt_q;
  assign aux_if.rise_pls   = rise_q;
  assign aux_if.fall_pls   = fall_q;
  assign aux_if.busy       = busy_q;
  assign aux_if.glitch_cnt = glitch_q;

endmodule

`default_nettype wire

// File: tb/tb_itrx_aib_aux_sigfilt.sv
// +-------------------------------------------------------------------------+
// | tb_itrx_aib_aux_sigfilt : scoreboard bench with a run-length model      |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

module tb_itrx_aib_aux_sigfilt;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam bit RSTL = 1'b0;

  typedef struct {
    int cyc;
    bit filt;
    bit rise;
    bit fall;
    bit busy;
    int glitch;
  } exp_t;

  logic clk;
  logic rst;
  itrx_aib_aux_sigfilt_if aux_if ();

  itrx_aib_aux_sigfilt #(
    .SYNC_STAGES (SYNC),
    .DEB_CYCLES  (DEB),
    .RST_LVL     (RSTL)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .aux_if (aux_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;

  // Model: a delay line for the synchronizer, and the length of the current
  // run of samples that disagree with the filtered level.
  bit   m_dly[$];
  bit   m_filt;
  int   m_run;
  int   m_glitch;

  function automatic void check(string nm, int c, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, c, got, exp);
  endfunction

  task automatic model_edge(bit r, bit e, bit l);
    exp_t x;
    bit   s;
    bit   rise = 1'b0;
    bit   fall = 1'b0;
    if (r) begin
      m_dly = {};
      for (int i = 0; i < SYNC; i++) m_dly.push_back(RSTL);
      m_filt   = RSTL;
      m_run    = 0;
      m_glitch = 0;
    end else begin
      s = m_dly[SYNC-1];
      m_dly.push_front(l);
      void'(m_dly.pop_back());
      if (!e) begin
        m_filt = RSTL;
        m_run  = 0;
      end else if (s != m_filt) begin
        m_run++;
        if (m_run == DEB) begin
          m_filt = s;
          rise   = s;
          fall   = !s;
          m_run  = 0;
        end
      end else begin
        if (m_run > 0 && m_glitch < 255) m_glitch++;
        m_run = 0;
      end
    end
    x.cyc    = cyc;
    x.filt   = m_filt;
    x.rise   = rise;
    x.fall   = fall;
    x.busy   = (m_run > 0);
    x.glitch = m_glitch;
    sb.push_back(x);
  endtask

  task automatic step(bit r, bit e, bit l);
    @(negedge clk);
    rst            = r;
    aux_if.en      = e;
    aux_if.lvs_out = l;
    @(posedge clk);
    cyc++;
    model_edge(r, e, l);
  endtask

  task automatic hold(bit l, int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, l);
  endtask

  // Monitor: registered outputs are stable by the falling edge.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        x = sb.pop_front();
        check("filt_out",   x.cyc, int'(aux_if.filt_out),   int'(x.filt));
        check("rise_pls",   x.cyc, int'(aux_if.rise_pls),   int'(x.rise));
        check("fall_pls",   x.cyc, int'(aux_if.fall_pls),   int'(x.fall));
        check("busy",       x.cyc, int'(aux_if.busy),       int'(x.busy));
        check("glitch_cnt", x.cyc, int'(aux_if.glitch_cnt), x.glitch);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int len;
    bit lvl;
    bit e;
    rst            = 1'b1;
    aux_if.en      = 1'b1;
    aux_if.lvs_out = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);

    // Clean rise and fall, then a 1-cycle and a 3-cycle high glitch.
    hold(1'b0, 3);
    hold(1'b1, 10);
    hold(1'b0, 10);
    hold(1'b1, 1);
    hold(1'b0, 6);
    hold(1'b1, 3);
    hold(1'b0, 6);

    // Settle high, reject a 3-cycle low pulse, then disable while high.
    hold(1'b1, 10);
    hold(1'b0, 3);
    hold(1'b1, 6);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
    hold(1'b1, 10);

    // Saturate the glitch counter.
    hold(1'b0, 10);
    for (int i = 0; i < 300; i++) begin
      hold(1'b1, 1);
      hold(1'b0, 2);
    end
    @(negedge clk);
    check("glitch_sat", cyc, int'(aux_if.glitch_cnt), 255);

    // Reset in the middle of a qualification, then a full re-qualification.
    hold(1'b1, 4);
    step(1'b1, 1'b1, 1'b1);
    hold(1'b1, 10);

    // Randomized runs with occasional disable and reset.
    lvl = 1'b0;
    for (int i = 0; i < 400; i++) begin
      len = $urandom_range(1, 7);
      lvl = ~lvl;
      e   = ($urandom_range(0, 15) != 0);
      for (int k = 0; k < len; k++) begin
        step(($urandom_range(0, 127) == 0), e, lvl);
      end
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("sb_drain", cyc, sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
